// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared constants, types and byte-enable helper for the vector store path
package vec_pkg;

    localparam int NUM_LANES      = 16;
    localparam int LANE_WIDTH     = 16;
    localparam int VEC_WIDTH      = 256;
    localparam int BEAT_WIDTH     = 32;
    localparam int BEATS          = 8;
    localparam int LANES_PER_BEAT = 2;

    typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

    typedef logic [NUM_LANES-1:0] lane_mask_t;

    // Each 16-bit lane covers two bytes of the 32-bit beat.
    function automatic logic [3:0] beat_be(input lane_mask_t mask, input logic [2:0] idx);
        logic [1:0] pair;
        pair = mask[{idx, 1'b0} +: 2];
        return {pair[1], pair[1], pair[0], pair[0]};
    endfunction

endpackage

// File: rtl/vec_beat_picker.sv
// rtl/vec_beat_picker.sv - finds the lowest active beat at or above a start index
module vec_beat_picker
    import vec_pkg::*;
(
    input  logic [15:0] mask_i,
    input  logic [3:0]  start_i,
    output logic [2:0]  next_idx_o,
    output logic        found_o
);

    // Scanning downward leaves the lowest qualifying beat as the final assignment.
    always_comb begin
        next_idx_o = 3'd0;
        found_o    = 1'b0;
        for (int k = BEATS - 1; k >= 0; k--) begin
            if ((4'(k) >= start_i) && (|mask_i[LANES_PER_BEAT*k +: LANES_PER_BEAT])) begin
                next_idx_o = 3'(k);
                found_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vec_store_serializer.sv
// rtl/vec_store_serializer.sv - writes a masked 256-bit vector to memory as 32-bit beats
module vec_store_serializer #(
    parameter int VEC_WIDTH  = vec_pkg::VEC_WIDTH,
    parameter int LANE_WIDTH = vec_pkg::LANE_WIDTH,
    parameter int BEAT_WIDTH = vec_pkg::BEAT_WIDTH,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [VEC_WIDTH-1:0]             in_data,
    input  logic [ADDR_WIDTH-1:0]            in_addr,
    input  logic [VEC_WIDTH/LANE_WIDTH-1:0]  in_mask,
    output logic                             mem_valid,
    input  logic                             mem_ready,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [BEAT_WIDTH-1:0]            mem_wdata,
    output logic [3:0]                       mem_be,
    output logic                             busy,
    output logic                             done
);
    import vec_pkg::*;

    state_t                  state_q, state_d;
    logic [VEC_WIDTH-1:0]    data_q, data_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    lane_mask_t              mask_q, mask_d;
    logic [2:0]              idx_q, idx_d;
    logic                    mem_valid_q, mem_valid_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [BEAT_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]              mem_be_q, mem_be_d;

    logic [VEC_WIDTH-1:0]    load_data;
    logic [ADDR_WIDTH-1:0]   load_base;
    lane_mask_t              load_mask;
    logic [3:0]              pick_start;
    logic [2:0]              pick_idx;
    logic                    pick_found;

    // In IDLE the picker looks at the incoming request; otherwise at the latched one.
    assign load_data  = (state_q == IDLE) ? in_data : data_q;
    assign load_base  = (state_q == IDLE) ? (in_addr & ~ADDR_WIDTH'(3)) : base_q;
    assign load_mask  = (state_q == IDLE) ? in_mask : mask_q;
    assign pick_start = (state_q == IDLE) ? 4'd0 : ({1'b0, idx_q} + 4'd1);

    vec_beat_picker u_picker (
        .mask_i     (load_mask),
        .start_i    (pick_start),
        .next_idx_o (pick_idx),
        .found_o    (pick_found)
    );

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        base_d      = base_q;
        mask_d      = mask_q;
        idx_d       = idx_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d = load_data;
                    base_d = load_base;
                    mask_d = load_mask;
                    state_d = pick_found ? SEND : FIN;
                end
            end
            SEND: begin
                if (mem_ready) begin
                    state_d = pick_found ? SEND : FIN;
                end
            end
            default: state_d = IDLE;
        endcase
        // Load the next beat whenever a new one is picked, from accept or from handshake.
        if (((state_q == IDLE) && in_valid) || ((state_q == SEND) && mem_ready)) begin
            mem_valid_d = pick_found;
            if (pick_found) begin
                idx_d       = pick_idx;
                mem_addr_d  = load_base + ADDR_WIDTH'({pick_idx, 2'b00});
                mem_wdata_d = load_data[BEAT_WIDTH*int'(pick_idx) +: BEAT_WIDTH];
                mem_be_d    = beat_be(load_mask, pick_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            base_q      <= '0;
            mask_q      <= '0;
            idx_q       <= '0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            base_q      <= base_d;
            mask_q      <= mask_d;
            idx_q       <= idx_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_vec_store_serializer.sv
// tb/tb_vec_store_serializer.sv - self-checking bench for vec_store_serializer
module tb_vec_store_serializer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_data;
    logic [31:0]  in_addr;
    logic [15:0]  in_mask;
    logic         mem_valid;
    logic         mem_ready;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_be;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    vec_store_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_addr   (in_addr),
        .in_mask   (in_mask),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .busy      (busy),
        .done      (done)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } beat_t;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] mask;
        int          exp_beats;
        int          exp_done;
    } vec_t;

    beat_t exp_q[$];
    int    tests = 0;
    int    fails = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [255:0] rand_vec();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Expected beats straight from the rules: one per beat with any lane enabled, in order.
    task automatic build_model(input logic [255:0] d, input logic [31:0] a, input logic [15:0] m);
        beat_t       b;
        logic [31:0] base;
        exp_q.delete();
        base = a & 32'hFFFF_FFFC;
        for (int k = 0; k < 8; k++) begin
            if (m[2*k] || m[2*k+1]) begin
                b.addr = base + 32'(4 * k);
                b.data = d[32*k +: 32];
                b.be   = {m[2*k+1], m[2*k+1], m[2*k], m[2*k]};
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic run_req(input logic [255:0] d, input logic [31:0] a, input logic [15:0] m,
                           input int stall_pct, input int stall_beat, input int stall_len,
                           output int done_cyc, output int nbeats);
        beat_t b;
        beat_t held;
        bit    hold;
        int    cyc;
        int    valid_cycles;
        int    stall_left;
        build_model(d, a, m);
        check("in_ready_before", 64'(in_ready), 64'(1));
        in_valid = 1'b1; in_data = d; in_addr = a; in_mask = m; mem_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = rand_vec(); in_addr = $urandom; in_mask = 16'($urandom);
        cyc = 1; valid_cycles = 0; nbeats = 0; hold = 1'b0; held = '0;
        stall_left = stall_len; done_cyc = -1;
        while (cyc < 300) begin
            if (stall_beat >= 0) begin
                mem_ready = 1'b1;
                if (nbeats == stall_beat && stall_left > 0 && mem_valid) begin
                    mem_ready = 1'b0;
                    stall_left--;
                end
            end else begin
                mem_ready = ($urandom_range(99) >= stall_pct);
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (hold) begin
                check("hold_valid", 64'(mem_valid), 64'(1));
                check("hold_beat", 64'({mem_addr, mem_wdata}), 64'({held.addr, held.data}));
                check("hold_be", 64'(mem_be), 64'(held.be));
            end
            if (mem_valid) begin
                valid_cycles++;
                if (exp_q.size() == 0) begin
                    check("extra_beat", 64'(mem_addr), 64'(0) - 64'(1));
                end else if (mem_ready) begin
                    b = exp_q.pop_front();
                    check("beat_addr", 64'(mem_addr), 64'(b.addr));
                    check("beat_wdata", 64'(mem_wdata), 64'(b.data));
                    check("beat_be", 64'(mem_be), 64'(b.be));
                    nbeats++;
                end
            end
            hold = mem_valid && !mem_ready;
            held.addr = mem_addr; held.data = mem_wdata; held.be = mem_be;
            @(posedge clk); #1;
            cyc++;
        end
        mem_ready = 1'b1;
        if (done_cyc < 0) begin
            check("done_timeout", 64'(0), 64'(1));
        end else begin
            check("fin_busy", 64'(busy), 64'(1));
            check("fin_in_ready", 64'(in_ready), 64'(0));
            check("fin_mem_valid", 64'(mem_valid), 64'(0));
            check("done_vs_beats", 64'(done_cyc), 64'(valid_cycles + 1));
            check("beats_missing", 64'(exp_q.size()), 64'(0));
            @(posedge clk); #1;
            check("done_pulse_width", 64'(done), 64'(0));
            check("in_ready_after", 64'(in_ready), 64'(1));
        end
    endtask

    initial begin
        vec_t         tbl[7];
        int           dc;
        int           nb;
        int           late_done;
        logic [15:0]  m;
        logic [255:0] d;

        tbl[0] = '{32'h0000_1000, 16'hFFFF, 8, 9};
        tbl[1] = '{32'h0000_1000, 16'h0201, 2, 3};
        tbl[2] = '{32'h0000_1000, 16'h0000, 0, 1};
        tbl[3] = '{32'hFFFF_FFF3, 16'hFFFF, 8, 9};
        tbl[4] = '{32'h0000_0020, 16'h8000, 1, 2};
        tbl[5] = '{32'h0000_0042, 16'h5555, 8, 9};
        tbl[6] = '{32'h0000_0080, 16'h00C0, 1, 2};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_addr = '0; in_mask = '0; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_mem_valid", 64'(mem_valid), 64'(0));
        check("rst_busy_done", 64'({busy, done}), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_wdata_be", 64'({mem_wdata, mem_be}), 64'(0));

        foreach (tbl[i]) begin
            run_req(rand_vec(), tbl[i].addr, tbl[i].mask, 0, -1, 0, dc, nb);
            check($sformatf("tbl%0d_beats", i), 64'(nb), 64'(tbl[i].exp_beats));
            check($sformatf("tbl%0d_done_cycle", i), 64'(dc), 64'(tbl[i].exp_done));
        end

        run_req(rand_vec(), 32'h0000_2000, 16'hFFFF, 0, 2, 3, dc, nb);
        check("bp_beats", 64'(nb), 64'(8));
        check("bp_done_cycle", 64'(dc), 64'(12));

        d = rand_vec();
        in_valid = 1'b1; in_data = d; in_addr = 32'h0000_3000; in_mask = 16'hFFFF; mem_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("rst_mid_pre_addr", 64'(mem_addr), 64'(32'h0000_300C));
        check("rst_mid_pre_wdata", 64'(mem_wdata), 64'(d[127:96]));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_mem_valid", 64'(mem_valid), 64'(0));
        check("rst_mid_busy", 64'(busy), 64'(0));
        check("rst_mid_in_ready", 64'(in_ready), 64'(1));
        late_done = 0;
        repeat (4) begin
            if (done || mem_valid) late_done++;
            @(posedge clk); #1;
        end
        check("rst_mid_no_done", 64'(late_done), 64'(0));
        run_req(rand_vec(), 32'h0000_4000, 16'hFFFF, 0, -1, 0, dc, nb);
        check("post_rst_beats", 64'(nb), 64'(8));
        check("post_rst_done_cycle", 64'(dc), 64'(9));

        for (int r = 0; r < 25; r++) begin
            int exp_nb;
            m = ($urandom_range(4) == 0) ? 16'h0000 : (16'($urandom) & 16'($urandom));
            exp_nb = 0;
            for (int k = 0; k < 8; k++) if (m[2*k] || m[2*k+1]) exp_nb++;
            run_req(rand_vec(), $urandom, m, 35, -1, 0, dc, nb);
            check($sformatf("rand%0d_beats", r), 64'(nb), 64'(exp_nb));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
